hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Consumer side of the decode/execute pipeline register. Reads the ID/EX
//  mem-read control bit and destination register address and compares them
//  with the IF/ID source registers. On a load-use hazard it stalls PC and
//  IF/ID and injects a bubble into ID/EX. On a taken branch from EX it
//  flushes IF/ID. It also keeps a saturating count of stall cycles.
// PARAMETERS
//  REG_ADDR_W    6   register address width (matches ID/EX reg_addr/rs fields)
//  LOAD_LAT      1   stall cycles per load-use hazard, legal 1..15
//  FLUSH_CYCLES  1   flush cycles per taken branch, legal 1..15
//  CNT_W         16  width of stall_count
// PORTS
//  clk            in   1           single clock; all state changes on posedge
//  rst            in   1           asynchronous, active-high reset
//  idex_mem_read  in   1           load in EX (mem_ctrl read bit of ID/EX)
//  idex_reg_addr  in   REG_ADDR_W  destination reg of the instruction in EX
//  ifid_rs        in   REG_ADDR_W  source reg 1 of the instruction in decode
//  ifid_rt        in   REG_ADDR_W  source reg 2 of the instruction in decode
//  ifid_uses_rs   in   1           decode instruction reads rs
//  ifid_uses_rt   in   1           decode instruction reads rt
//  branch_taken   in   1           EX resolved a taken branch this cycle
//  pc_write_en    out  1           0 = hold PC
//  ifid_write_en  out  1           0 = hold IF/ID
//  ifid_flush     out  1           1 = load NOP into IF/ID
//  idex_bubble    out  1           1 = zero ex/mem/wb ctrl into ID/EX
//  hazard_state   out  2           current FSM state (debug)
//  stall_count    out  CNT_W       cycles with pc_write_en==0, saturating
// BEHAVIOUR
//  load_use = idex_mem_read & (idex_reg_addr!=0) &
//    ((ifid_uses_rs & idex_reg_addr==ifid_rs) | (ifid_uses_rt & idex_reg_addr==ifid_rt))
//  Register 0 is hardwired zero and never causes a hazard.
//  FSM states: RUN=0, LOAD_STALL=1, FLUSH=2. Register rem[3:0] holds the
//  remaining cycles.
//  Outputs are combinational from state and inputs (Mealy), so the action
//  happens in the same cycle the hazard is detected.
//  RUN:
//   - branch_taken: flush=1, bubble=1, pc_we=1, ifid_we=1.
//     If FLUSH_CYCLES>1, go to FLUSH with rem=FLUSH_CYCLES-1.
//   - else load_use: pc_we=0, ifid_we=0, bubble=1, flush=0.
//     If LOAD_LAT>1, go to LOAD_STALL with rem=LOAD_LAT-1.
//   - else: pc_we=1, ifid_we=1, bubble=0, flush=0.
//  LOAD_STALL:
//   - Same outputs as load_use. rem decrements; at rem==1 return to RUN
//     on the next edge.
//   - branch_taken has priority: abort the stall and apply the RUN
//     branch_taken outputs and transition.
//  FLUSH:
//   - flush=1, bubble=1, pc_we=1, ifid_we=1. rem decrements; at rem==1
//     return to RUN.
//   - A new branch_taken reloads rem=FLUSH_CYCLES-1.
//   - load_use is ignored (IF/ID is being flushed).
//  Simultaneous branch_taken and load_use: branch wins, no stall.
//  stall_count: +1 on each posedge where pc_write_en==0. Holds at
//   2^CNT_W-1; never wraps.
//  Reset (asynchronous, active-high):
//   - state=RUN, rem=0, stall_count=0.
//   - While rst=1: pc_write_en=0, ifid_write_en=0, ifid_flush=1,
//     idex_bubble=1, hazard_state=0.
//   - Reset asserted mid-stall or mid-flush abandons it immediately.
//   - First cycle after release behaves as RUN.
// STRUCTURE
//  pipe_pkg: hazard_state encodings (RUN/LOAD_STALL/FLUSH), REG_ZERO constant,
//   and the ID/EX mem_ctrl bit index for mem-read.
//  Sub-module sat_counter #(CNT_W) (clk, rst, inc, count) implements
//   stall_count.
//  FSM and hazard compare live in this module.
// TESTING
//  1. LOAD_LAT=1: idex_mem_read=1, idex_reg_addr=5, ifid_rs=5, uses_rs=1
//     -> pc_we=0, ifid_we=0, bubble=1 for exactly 1 cycle; stall_count=1.
//  2. idex_reg_addr=0=ifid_rs, mem_read=1 -> no stall; and rt match with
//     uses_rt=0 -> no stall.
//  3. LOAD_LAT=3: hazard on rt=9 -> stall held 3 cycles, state 0->1->1->0,
//     stall_count=3.
//  4. FLUSH_CYCLES=2: branch_taken together with load_use -> flush=1,
//     bubble=1, pc_we=1 for 2 cycles; stall_count unchanged.
//  5. LOAD_LAT=4: branch_taken on the 2nd stall cycle -> stall aborted,
//     flush starts that cycle.
//  6. rst pulsed mid-stall -> outputs take reset values asynchronously;
//     stall_count=0; after release a matching hazard stalls again.
//     CNT_W=2 with 5 stalls -> stall_count saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings and ID/EX field constants.
package pipe_pkg;

  // Hazard unit FSM states; the encodings are visible on the hazard_state debug port.
  typedef enum logic [1:0] {
    HS_RUN        = 2'd0,
    HS_LOAD_STALL = 2'd1,
    HS_FLUSH      = 2'd2
  } hazard_state_e;

  // Register 0 is hardwired to zero, so writing it never creates a dependency.
  localparam int REG_ZERO = 0;

  // Bit position of the mem-read control bit inside the ID/EX mem_ctrl field.
  localparam int MEM_CTRL_READ_BIT = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on each enabled edge unless already saturated; async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall and taken-branch flush control for the IF/ID and ID/EX registers.
// Outputs are Mealy: the stall/flush action happens in the same cycle the
// condition is seen, and the FSM only carries the extra cycles beyond the first.
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = 6,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_reg_addr,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rs,
  input  logic                  ifid_uses_rt,
  input  logic                  branch_taken,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [1:0]            hazard_state,
  output logic [CNT_W-1:0]      stall_count
);

  // Remaining-cycle reload values after the first (detection) cycle.
  localparam logic [3:0] LOAD_REM  = 4'(LOAD_LAT - 1);
  localparam logic [3:0] FLUSH_REM = 4'(FLUSH_CYCLES - 1);

  hazard_state_e state_q, state_d;
  logic [3:0]    rem_q, rem_d;
  logic          load_use;

  // Load in EX whose destination is a source actually read by the decode instruction.
  always_comb begin
    load_use = idex_mem_read
             && (idex_reg_addr != REG_ADDR_W'(REG_ZERO))
             && ((ifid_uses_rs && (idex_reg_addr == ifid_rs))
              || (ifid_uses_rt && (idex_reg_addr == ifid_rt)));
  end

  // State and remaining-cycle register; reset abandons any stall or flush in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HS_RUN;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state and pipeline-control outputs; branch always outranks a load-use stall.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    if (rst) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      state_d       = HS_RUN;
      rem_d         = 4'd0;
    end else begin
      case (state_q)
        HS_RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = HS_FLUSH;
              rem_d   = FLUSH_REM;
            end
          end else if (load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = HS_LOAD_STALL;
              rem_d   = LOAD_REM;
            end
          end
        end
        HS_LOAD_STALL: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = HS_FLUSH;
              rem_d   = FLUSH_REM;
            end else begin
              state_d = HS_RUN;
              rem_d   = 4'd0;
            end
          end else begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            if (rem_q == 4'd1) begin
              state_d = HS_RUN;
              rem_d   = 4'd0;
            end else begin
              rem_d = rem_q - 4'd1;
            end
          end
        end
        HS_FLUSH: begin
          // IF/ID holds a squashed instruction, so its source registers are meaningless.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            rem_d = FLUSH_REM;
          end else if (rem_q == 4'd1) begin
            state_d = HS_RUN;
            rem_d   = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
        default: begin
          state_d = HS_RUN;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  assign hazard_state = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~pc_write_en),
    .count(stall_count)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Three hazard units with different parameters share one input stream; a
// behavioural model produces expected outputs, queued at drive time and
// compared mid-cycle before the next rising edge.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst;
  logic       in_mr;
  logic [5:0] in_ra;
  logic [5:0] in_rs;
  logic [5:0] in_rt;
  logic       in_urs;
  logic       in_urt;
  logic       in_br;

  logic       pc_we_o [3];
  logic       ifid_we_o [3];
  logic       flush_o [3];
  logic       bubble_o [3];
  logic [1:0] state_o [3];
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [15:0] cnt_c;

  int n_checks = 0;
  int n_errors = 0;
  logic [21:0] exp_q[$];

  // Model state per instance: a = (LAT 1, FLUSH 1, CNT 16), b = (3, 2, 2), c = (4, 2, 16)
  int m_state [3];
  int m_rem [3];
  int m_cnt [3];
  int lat [3]  = '{1, 3, 4};
  int fl [3]   = '{1, 2, 2};
  int cmax [3] = '{65535, 3, 65535};

  hazard_ctrl_unit #(.REG_ADDR_W(6), .LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .idex_mem_read(in_mr), .idex_reg_addr(in_ra),
    .ifid_rs(in_rs), .ifid_rt(in_rt), .ifid_uses_rs(in_urs), .ifid_uses_rt(in_urt),
    .branch_taken(in_br), .pc_write_en(pc_we_o[0]), .ifid_write_en(ifid_we_o[0]),
    .ifid_flush(flush_o[0]), .idex_bubble(bubble_o[0]), .hazard_state(state_o[0]),
    .stall_count(cnt_a));

  hazard_ctrl_unit #(.REG_ADDR_W(6), .LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .idex_mem_read(in_mr), .idex_reg_addr(in_ra),
    .ifid_rs(in_rs), .ifid_rt(in_rt), .ifid_uses_rs(in_urs), .ifid_uses_rt(in_urt),
    .branch_taken(in_br), .pc_write_en(pc_we_o[1]), .ifid_write_en(ifid_we_o[1]),
    .ifid_flush(flush_o[1]), .idex_bubble(bubble_o[1]), .hazard_state(state_o[1]),
    .stall_count(cnt_b));

  hazard_ctrl_unit #(.REG_ADDR_W(6), .LOAD_LAT(4), .FLUSH_CYCLES(2), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .idex_mem_read(in_mr), .idex_reg_addr(in_ra),
    .ifid_rs(in_rs), .ifid_rt(in_rt), .ifid_uses_rs(in_urs), .ifid_uses_rt(in_urt),
    .branch_taken(in_br), .pc_write_en(pc_we_o[2]), .ifid_write_en(ifid_we_o[2]),
    .ifid_flush(flush_o[2]), .idex_bubble(bubble_o[2]), .hazard_state(state_o[2]),
    .stall_count(cnt_c));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] dut_vec(input int i);
    logic [15:0] c;
    case (i)
      0:       c = cnt_a;
      1:       c = {14'd0, cnt_b};
      default: c = cnt_c;
    endcase
    return {pc_we_o[i], ifid_we_o[i], flush_o[i], bubble_o[i], state_o[i], c};
  endfunction

  // Expected outputs for the current inputs plus the state after the next edge.
  task automatic model_eval(input int i, output logic [21:0] e,
                            output int ns, output int nr, output int nc);
    logic pc, iw, fsh, bub, lu;
    lu = in_mr && (in_ra != 6'd0) &&
         ((in_urs && (in_ra == in_rs)) || (in_urt && (in_ra == in_rt)));
    ns = m_state[i]; nr = m_rem[i];
    pc = 1'b1; iw = 1'b1; fsh = 1'b0; bub = 1'b0;
    if (rst) begin
      e  = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'd0};
      ns = 0; nr = 0; nc = 0;
    end else begin
      if (m_state[i] == 0) begin
        if (in_br) begin
          fsh = 1'b1; bub = 1'b1;
          if (fl[i] > 1) begin ns = 2; nr = fl[i] - 1; end
        end else if (lu) begin
          pc = 1'b0; iw = 1'b0; bub = 1'b1;
          if (lat[i] > 1) begin ns = 1; nr = lat[i] - 1; end
        end
      end else if (m_state[i] == 1) begin
        if (in_br) begin
          fsh = 1'b1; bub = 1'b1;
          if (fl[i] > 1) begin ns = 2; nr = fl[i] - 1; end
          else begin ns = 0; nr = 0; end
        end else begin
          pc = 1'b0; iw = 1'b0; bub = 1'b1;
          if (m_rem[i] == 1) begin ns = 0; nr = 0; end
          else nr = m_rem[i] - 1;
        end
      end else begin
        fsh = 1'b1; bub = 1'b1;
        if (in_br) nr = fl[i] - 1;
        else if (m_rem[i] == 1) begin ns = 0; nr = 0; end
        else nr = m_rem[i] - 1;
      end
      nc = (!pc && (m_cnt[i] < cmax[i])) ? m_cnt[i] + 1 : m_cnt[i];
      e  = {pc, iw, fsh, bub, 2'(m_state[i]), 16'(m_cnt[i])};
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge, check mid-cycle, advance model.
  task automatic drive(input logic r, input logic mr, input logic [5:0] ra,
                       input logic [5:0] rs, input logic [5:0] rt,
                       input logic urs, input logic urt, input logic br);
    int ns [3];
    int nr [3];
    int nc [3];
    logic [21:0] e;
    logic [21:0] g;
    rst = r; in_mr = mr; in_ra = ra; in_rs = rs; in_rt = rt;
    in_urs = urs; in_urt = urt; in_br = br;
    #1;
    for (int i = 0; i < 3; i++) begin
      model_eval(i, e, ns[i], nr[i], nc[i]);
      exp_q.push_back(e);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      g = dut_vec(i);
      check_eq($sformatf("dut%0d.pc_write_en", i),   32'(g[21]), 32'(e[21]));
      check_eq($sformatf("dut%0d.ifid_write_en", i), 32'(g[20]), 32'(e[20]));
      check_eq($sformatf("dut%0d.ifid_flush", i),    32'(g[19]), 32'(e[19]));
      check_eq($sformatf("dut%0d.idex_bubble", i),   32'(g[18]), 32'(e[18]));
      check_eq($sformatf("dut%0d.hazard_state", i),  32'(g[17:16]), 32'(e[17:16]));
      check_eq($sformatf("dut%0d.stall_count", i),   32'(g[15:0]), 32'(e[15:0]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_state[i] = ns[i]; m_rem[i] = nr[i]; m_cnt[i] = nc[i];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_state[i] = 0; m_rem[i] = 0; m_cnt[i] = 0; end
    rst = 1'b1; in_mr = 1'b0; in_ra = '0; in_rs = '0; in_rt = '0;
    in_urs = 1'b0; in_urt = 1'b0; in_br = 1'b0;
    @(negedge clk);
    // Reset values held while rst is high
    drive(1'b1, 1'b1, 6'd5, 6'd5, 6'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Load-use on rs, single cycle of stimulus
    drive(1'b0, 1'b1, 6'd5, 6'd5, 6'd7, 1'b1, 1'b0, 1'b0);
    idle(5);
    // Register 0 never hazards; rt match ignored when rt unused
    drive(1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 6'd9, 6'd3, 6'd9, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 6'd9, 6'd9, 6'd9, 1'b1, 1'b1, 1'b0);
    idle(1);
    // Load-use on rt=9
    drive(1'b0, 1'b1, 6'd9, 6'd1, 6'd9, 1'b0, 1'b1, 1'b0);
    idle(5);
    // Branch together with load-use: branch wins
    drive(1'b0, 1'b1, 6'd4, 6'd4, 6'd4, 1'b1, 1'b1, 1'b1);
    idle(3);
    // Branch on the second stall cycle aborts the stall
    drive(1'b0, 1'b1, 6'd6, 6'd6, 6'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    idle(4);
    // Back-to-back branches reload the flush
    drive(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Reset pulsed mid-stall, then a fresh hazard stalls again
    drive(1'b0, 1'b1, 6'd8, 6'd8, 6'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 6'd8, 6'd8, 6'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 6'd8, 6'd8, 6'd0, 1'b1, 1'b0, 1'b0);
    idle(5);
    // Repeated stalls drive the 2-bit counter into saturation
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 6'd2, 6'd2, 6'd2, 1'b1, 1'b1, 1'b0);
      idle(4);
    end
    #2;
    check_eq("sat_b.stall_count", 32'(cnt_b), 32'd3);
    @(negedge clk);
    // Random traffic with a small register space to force collisions
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
    end
    check_eq("exp_q.empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
